pulse_width_meter: RTL and testbench
====================================

Name: pulse_width_meter

Overview:
- Downstream consumer of the single-bit level output `b` of the SVA demo block `abc`.
- Detects rising and falling edges of that level and measures each high pulse in clock cycles.
- Queues one record per completed pulse in a small FIFO, drained through a valid/ready interface.
- Used as a measurement sink so SVA benches can check pulse timing against a stored record stream.

Parameters:
- CNT_W, 8, width counter bits; record width is CNT_W+1.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PCNT_W, 16, width of the completed-pulse counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  level to measure (`b` of `abc`); synchronous to clk.
- rise_o  output  1  one-cycle pulse on a detected rising edge.
- fall_o  output  1  one-cycle pulse on a detected falling edge.
- m_valid  output  1  FIFO head record available.
- m_ready  input  1  consumer accepts head when m_valid & m_ready.
- m_data  output  CNT_W+1  head record {sat, width[CNT_W-1:0]}.
- ovf  output  1  sticky flag: a record was dropped because the FIFO was full.
- clr_ovf  input  1  synchronous clear of ovf.
- pulse_cnt  output  PCNT_W  completed pulses, including dropped ones; wraps.

Behaviour:
- Reset values while rst is high:
  - state=ARM; din_q=0.
  - rise_o, fall_o, m_valid, ovf all 0.
  - m_data=0; pulse_cnt=0.
  - FIFO pointers and count cleared; width counter cleared.
- All state is updated on the clk rising edge; every output is registered.
- Edge k denotes a clk rising edge; "sample" means the value of din at that edge.
- FSM states:
  - ARM: wait for a sample of din=0, then go to IDLE. No edges reported. This discards any pulse already in progress at reset release.
  - IDLE: on a sample of din=1, go to HIGH, load width=1, clear sat. rise_o is 1 for the cycle following edge k.
  - HIGH:
    - On a sample of din=1: width increments.
    - At width = 2^CNT_W-1, width holds and sat is set to 1.
    - On a sample of din=0: go to IDLE, fall_o is 1 for the cycle following edge k, and the record {sat, width} is written at edge k.
- Width definition: the number of edges sampling din=1 for that pulse. A single-cycle high gives width=1.
- pulse_cnt increments at every falling detection, whether the record is stored or dropped. It wraps modulo 2^PCNT_W.
- FIFO:
  - Synchronous, DEPTH entries; m_data is the head entry.
  - m_valid=1 whenever count>0.
  - A record written at edge k to an empty FIFO gives m_valid=1 in the same cycle fall_o=1; there is no bypass.
  - Pop occurs at an edge where m_valid & m_ready.
  - m_data is 0 when the FIFO is empty.
- Push and pop at the same edge:
  - Count is unchanged; both take effect.
  - When the FIFO is full, the push is accepted because the pop frees a slot. No drop, no ovf.
- Push when full without a pop: the record is dropped and ovf is set to 1 at that edge.
- ovf is cleared by clr_ovf. If clr_ovf and a new drop occur at the same edge, ovf ends at 1 (set wins).
- m_ready while m_valid=0 is ignored.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-pulse or with the FIFO occupied:
  - Everything clears immediately and asynchronously.
  - After release, the block re-enters ARM.

Test Plan:
- Reset release with din=1 held, then din=0 at edge 10: no rise_o, no fall_o, no record, pulse_cnt=0.
- din high for 5 sampled edges, m_ready=1:
  - rise_o and fall_o each pulse once.
  - m_data=0x005 with m_valid for 1 cycle; pulse_cnt=1.
- din high for 300 edges with CNT_W=8: record {sat=1, width=255} (m_data=0x1FF).
- m_ready=0, five pulses of widths 1, 2, 3, 4, 5 with DEPTH=4:
  - Records 1, 2, 3, 4 are held; the fifth is dropped.
  - ovf=1, pulse_cnt=5.
  - Then m_ready=1 drains 0x001, 0x002, 0x003, 0x004 in order and m_valid returns to 0.
- FIFO full, falling edge coinciding with a pop: no ovf, count stays 4, and the new record appears last in drain order.
- clr_ovf pulsed while ovf=1 with no drop: ovf=0 the next cycle. clr_ovf coinciding with a drop: ovf stays 1.

Source files
------------

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - high-pulse width meter with record FIFO and overflow flag
module pulse_width_meter #(
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic              rise_o,
    output logic              fall_o,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W:0]    m_data,
    output logic              ovf,
    input  logic              clr_ovf,
    output logic [PCNT_W-1:0] pulse_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = CNT_W + 1;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              din_q;
    logic [CNT_W-1:0]  width_q, width_d;
    logic              sat_q, sat_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              push;
    logic [RW-1:0]     rec;

    logic [RW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              m_valid_q, m_valid_d;
    logic [RW-1:0]     m_data_q, m_data_d;
    logic              ovf_q, ovf_d;
    logic [PCNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

    logic              pop, full, wr_en, drop;

    // Edge-detect FSM: ARM swallows a pulse already high at reset release
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        sat_d   = sat_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            ARM: begin
                if (!din) state_d = IDLE;
            end
            IDLE: begin
                if (din && !din_q) begin
                    state_d = HIGH;
                    width_d = CNT_W'(1);
                    sat_d   = 1'b0;
                    rise_d  = 1'b1;
                end
            end
            HIGH: begin
                if (din) begin
                    if (width_q == '1) sat_d = 1'b1;
                    else               width_d = width_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    fall_d  = 1'b1;
                    push    = 1'b1;
                end
            end
            default: state_d = ARM;
        endcase
    end

    assign rec = {sat_q, width_q};

    // FIFO bookkeeping; a pop at a full edge frees the slot for a same-edge push
    always_comb begin
        pop      = m_valid_q & m_ready;
        full     = (count_q == CW'(DEPTH));
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
        m_valid_d = (count_d != '0);
        // Head after this edge is the new record when it lands in the head slot
        if (count_d == '0)                     m_data_d = '0;
        else if (wr_en && wr_ptr_q == rd_ptr_d) m_data_d = rec;
        else                                   m_data_d = mem_q[rd_ptr_d];
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
        pulse_cnt_d = fall_d ? pulse_cnt_q + PCNT_W'(1) : pulse_cnt_q;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARM;
            din_q       <= 1'b0;
            width_q     <= '0;
            sat_q       <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            ovf_q       <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            din_q       <= din;
            width_q     <= width_d;
            sat_q       <= sat_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            ovf_q       <= ovf_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    // Record storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign ovf       = ovf_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        rise_o;
    logic        fall_o;
    logic        m_valid;
    logic        m_ready;
    logic [8:0]  m_data;
    logic        ovf;
    logic        clr_ovf;
    logic [15:0] pulse_cnt;

    int tests = 0;
    int fails = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    pulse_width_meter #(.CNT_W(8), .DEPTH(4), .PCNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rise_o === 1'b1) rise_seen++;
        if (fall_o === 1'b1) fall_seen++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int w);
        din = 1'b1;
        repeat (w) cyc();
        din = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; din = 1'b1; m_ready = 1'b0; clr_ovf = 1'b0;
        cyc(); cyc();
        check("rst_rise", 32'(rise_o), 32'd0);
        check("rst_fall", 32'(fall_o), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_pcnt", 32'(pulse_cnt), 32'd0);

        // Pulse in progress at release must be discarded
        rst = 1'b0;
        rise_seen = 0; fall_seen = 0;
        repeat (9) cyc();
        din = 1'b0;
        cyc(); cyc();
        check("arm_rise", 32'(rise_seen), 32'd0);
        check("arm_fall", 32'(fall_seen), 32'd0);
        check("arm_valid", 32'(m_valid), 32'd0);
        check("arm_pcnt", 32'(pulse_cnt), 32'd0);

        // Width-5 pulse drained immediately
        m_ready = 1'b1;
        rise_seen = 0; fall_seen = 0;
        din = 1'b1;
        cyc();
        check("p5_rise_o", 32'(rise_o), 32'd1);
        repeat (4) cyc();
        din = 1'b0;
        cyc();
        check("p5_fall_o", 32'(fall_o), 32'd1);
        check("p5_valid", 32'(m_valid), 32'd1);
        check("p5_data", 32'(m_data), 32'h005);
        check("p5_pcnt", 32'(pulse_cnt), 32'd1);
        cyc();
        check("p5_valid_gone", 32'(m_valid), 32'd0);
        check("p5_data_zero", 32'(m_data), 32'd0);
        check("p5_rise_cnt", 32'(rise_seen), 32'd1);
        check("p5_fall_cnt", 32'(fall_seen), 32'd1);

        // Saturation
        pulse(300);
        check("sat_valid", 32'(m_valid), 32'd1);
        check("sat_data", 32'(m_data), 32'h1FF);
        cyc();
        check("sat_pcnt", 32'(pulse_cnt), 32'd2);
        check("sat_empty", 32'(m_valid), 32'd0);

        // Fill, overflow, drain
        m_ready = 1'b0;
        pulse(1); pulse(2); pulse(3); pulse(4);
        check("fill_ovf0", 32'(ovf), 32'd0);
        pulse(5);
        check("drop_ovf", 32'(ovf), 32'd1);
        check("drop_pcnt", 32'(pulse_cnt), 32'd7);
        m_ready = 1'b1;
        check("drain0", 32'(m_data), 32'h001);
        cyc();
        check("drain1", 32'(m_data), 32'h002);
        cyc();
        check("drain2", 32'(m_data), 32'h003);
        cyc();
        check("drain3", 32'(m_data), 32'h004);
        cyc();
        check("drain_empty", 32'(m_valid), 32'd0);
        check("drain_zero", 32'(m_data), 32'd0);

        // clr_ovf without a drop
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);

        // clr_ovf coinciding with a drop: set wins
        m_ready = 1'b0;
        pulse(1); pulse(2); pulse(3); pulse(4);
        din = 1'b1;
        repeat (6) cyc();
        din = 1'b0; clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("clr_drop_ovf", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("clr_again", 32'(ovf), 32'd0);

        // Full FIFO: falling edge coincides with a pop
        din = 1'b1;
        repeat (7) cyc();
        din = 1'b0; m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        check("pp_ovf", 32'(ovf), 32'd0);
        check("pp_valid", 32'(m_valid), 32'd1);
        check("pp_head", 32'(m_data), 32'h002);
        check("pp_pcnt", 32'(pulse_cnt), 32'd13);
        m_ready = 1'b1;
        cyc();
        check("pp_d1", 32'(m_data), 32'h003);
        cyc();
        check("pp_d2", 32'(m_data), 32'h004);
        cyc();
        check("pp_d3", 32'(m_data), 32'h007);
        cyc();
        check("pp_empty", 32'(m_valid), 32'd0);

        // Asynchronous reset mid-pulse with data queued
        m_ready = 1'b0;
        pulse(2);
        din = 1'b1;
        cyc();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_pcnt", 32'(pulse_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        rise_seen = 0;
        repeat (3) cyc();
        check("arst_rearm", 32'(rise_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
